dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive locked grants to one port (range 1..15).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0 / req1  input  1  access request from port 0 (CPU data) / port 1 (DMA).
REQ-005 we0 / we1  input  1  1 = write, 0 = read, per port.
REQ-006 addr0 / addr1  input  [11:2]  word address per port.
REQ-007 wdata0 / wdata1  input  32  write data per port.
REQ-008 lock0 / lock1  input  1  burst-lock request per port; used only with DM_ARB_LOCK_EN.
REQ-009 gnt0 / gnt1  output  1  one-cycle grant pulse per port.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle read-data-valid pulse per port.
REQ-011 rdata  output  32  read data, shared by both ports, qualified by rvalid0/rvalid1.
REQ-012 m_addr  output  [11:2]  data-memory word address.
REQ-013 m_din  output  32  data-memory write data.
REQ-014 m_wEn  output  1  data-memory write enable; memory commits on the falling edge of clk.
REQ-015 m_dout  input  32  data-memory read data, combinational from m_addr.

Function
REQ-016 Requesters SHALL hold req, we, addr and wdata stable until they sample gnt=1; the arbiter SHALL latch the winner's payload on the edge that raises gnt.
REQ-017 Request sampled at edge k: gnt high and memory access during cycle k+1; read data on rdata with rvalid high during cycle k+2.
REQ-018 At most one gnt SHALL be high per cycle; gnt0 and gnt1 never high together.
REQ-019 m_wEn SHALL be high only during a grant cycle whose latched we=1; m_addr/m_din SHALL hold the latched payload during that cycle.
REQ-020 Reads: rdata SHALL be m_dout captured at the end of the grant cycle; rvalid of the granted port pulses one cycle. Writes produce no rvalid.
REQ-021 Single requester SHALL be granted; a request held high after gnt is a new request, allowing a grant every cycle (full throughput).
REQ-022 Both requesting: round-robin; the port not granted most recently wins; continuous dual requests SHALL alternate 0,1,0,1.
REQ-023 FSM states: IDLE (no grant this cycle), GRANT (grant issued this cycle), LOCK (locked burst, macro only); IDLE->GRANT on any req; GRANT->GRANT on any req; GRANT->IDLE on no req.
REQ-024 Read-after-write to the same address from either port SHALL return the newly written data (write commits on falling edge of grant cycle).
REQ-025 rdata SHALL hold its last value when no rvalid is high.

Reset
REQ-026 rst_n low SHALL immediately clear gnt0, gnt1, rvalid0, rvalid1, m_wEn; rdata, m_addr, m_din SHALL reset to 0; state to IDLE.
REQ-027 After reset the round-robin pointer SHALL favour port 0 (last-granted = port 1); burst counter = 0.
REQ-028 Reset during a grant cycle SHALL abort the access: no memory write, no rvalid; requesters re-request after release.

Configuration
REQ-029 Macro DM_ARB_LOCK_EN defined: while the granted port holds lock and req, it SHALL keep winning (state LOCK) up to MAX_BURST consecutive grants, after which the other port, if requesting, SHALL win one grant; lock release or req drop returns to round-robin.
REQ-030 DM_ARB_LOCK_EN undefined: lock0/lock1 SHALL be ignored, LOCK state and burst counter absent, pure round-robin.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, port index constants (PORT_CPU=0, PORT_DMA=1) and the address width constant (10).
REQ-032 One sub-module, dm_arb_rr, SHALL contain the two-way round-robin pick and last-granted pointer; datapath muxing stays in dm_arbiter.

Verification
REQ-033 Reset, req0=1 we0=1 addr0=0x010 wdata0=0xDEADBEEF -> gnt0 next cycle, m_wEn=1, m_addr=0x010; then read 0x010 -> rvalid0 two cycles after request, rdata=0xDEADBEEF.
REQ-034 req0 and req1 both held 6 cycles, reads -> grants 0,1,0,1,0,1; never both gnt high.
REQ-035 Port 1 writes 0x55AA55AA to 0x3FF while port 0 reads 0x3FF next cycle -> rvalid0 with rdata=0x55AA55AA.
REQ-036 rst_n pulsed low mid grant cycle of write 0x12345678 to 0x020 -> m_wEn drops immediately; later read of 0x020 returns prior value.
REQ-037 With DM_ARB_LOCK_EN, MAX_BURST=4: lock0=req0=1, req1=1 continuously -> grants 0,0,0,0,1,0,0,0,0,1.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-port data-memory arbiter.
// Build option: define DM_ARB_LOCK_EN to add the LOCK state for locked bursts.
package dm_arbiter_pkg;

    localparam int   ADDR_W   = 10;
    localparam int   BURST_W  = 4;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1
`ifdef DM_ARB_LOCK_EN
        ,
        ST_LOCK  = 2'd2
`endif
    } arb_state_t;

endpackage

// File: rtl/dm_arb_rr.sv
// Two-way round-robin pick plus the last-granted pointer (reset favours port 0).
// Identical in every build; DM_ARB_LOCK_EN overrides are applied by dm_arbiter.
module dm_arb_rr
    import dm_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_grant,
    input  logic i_grant_port,
    output logic o_pick_valid,
    output logic o_pick_port,
    output logic o_last_port
);

    logic r_last;

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_DMA;
        end else if (i_grant) begin
            r_last <= i_grant_port;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        o_pick_valid = i_req0 | i_req1;
        o_pick_port  = PORT_CPU;
        if (i_req0 && i_req1) begin
            o_pick_port = ~r_last;
        end else if (i_req1) begin
            o_pick_port = PORT_DMA;
        end
    end

    assign o_last_port = r_last;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port (CPU data / DMA) data-memory arbiter: registered grant, one-cycle access, rdata next cycle.
// Build option: DM_ARB_LOCK_EN enables locked bursts of up to MAX_BURST grants.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W+1:2] addr0,
    input  logic [ADDR_W+1:2] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [31:0]       rdata,
    output logic [ADDR_W+1:2] m_addr,
    output logic [31:0]       m_din,
    output logic              m_wEn,
    input  logic [31:0]       m_dout
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_pick_valid;
    logic              w_pick_port;
    logic              w_last_port;
    logic              w_win_port;
    logic              w_grant;
    logic              w_sel_we;
    logic [ADDR_W+1:2] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_rd_cycle;

    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_wen;
    logic [ADDR_W+1:2] r_addr;
    logic [31:0]       r_din;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [31:0]       r_rdata;

    dm_arb_rr u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req0       (req0),
        .i_req1       (req1),
        .i_grant      (w_grant),
        .i_grant_port (w_win_port),
        .o_pick_valid (w_pick_valid),
        .o_pick_port  (w_pick_port),
        .o_last_port  (w_last_port)
    );

`ifdef DM_ARB_LOCK_EN
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] w_burst_nxt;
    logic               w_owner_req;
    logic               w_owner_lock;
    logic               w_hold;

    // The port granted last cycle keeps the bus while it locks, until its burst is spent.
    assign w_owner_req  = (w_last_port == PORT_DMA) ? req1  : req0;
    assign w_owner_lock = (w_last_port == PORT_DMA) ? lock1 : lock0;
    assign w_hold       = (r_state != ST_IDLE) && w_owner_req && w_owner_lock &&
                          (r_burst < BURST_W'(MAX_BURST));

    always_comb begin
        w_burst_nxt = '0;
        if (w_grant) begin
            if ((r_state != ST_IDLE) && (w_win_port == w_last_port)) begin
                w_burst_nxt = (r_burst == '1) ? r_burst : r_burst + BURST_W'(1);
            end else begin
                w_burst_nxt = BURST_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst <= '0;
        end else begin
            r_burst <= w_burst_nxt;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = lock0 ^ lock1 ^ w_last_port ^ (MAX_BURST == 0);
`endif

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_win_port  = w_pick_port;
`ifdef DM_ARB_LOCK_EN
        if (w_hold) begin
            w_win_port  = w_last_port;
            w_state_nxt = ST_LOCK;
        end else
`endif
        if (w_pick_valid) begin
            w_state_nxt = ST_GRANT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_grant     = (w_state_nxt != ST_IDLE);
    assign w_sel_we    = (w_win_port == PORT_DMA) ? we1    : we0;
    assign w_sel_addr  = (w_win_port == PORT_DMA) ? addr1  : addr0;
    assign w_sel_wdata = (w_win_port == PORT_DMA) ? wdata1 : wdata0;

    // A grant cycle that is not a write is a read; its data is captured at the end of it.
    assign w_rd_cycle  = (r_state != ST_IDLE) && !r_wen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_gnt0    <= w_grant && (w_win_port == PORT_CPU);
            r_gnt1    <= w_grant && (w_win_port == PORT_DMA);
            r_wen     <= w_grant && w_sel_we;
            if (w_grant) begin
                r_addr <= w_sel_addr;
                r_din  <= w_sel_wdata;
            end
            r_rvalid0 <= w_rd_cycle && r_gnt0;
            r_rvalid1 <= w_rd_cycle && r_gnt1;
            if (w_rd_cycle) begin
                r_rdata <= m_dout;
            end
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = r_rdata;
    assign m_addr  = r_addr;
    assign m_din   = r_din;
    assign m_wEn   = r_wen;

endmodule
